fetch_ctrl: RTL

Sequencer for the program counter (pc) and the instruction fetch path. Drives pc's D/MODE/ENABLE, issues instruction-memory reads at PC_OUT, and presents each fetched word to decode through a valid/accept handshake. Applies redirects (jumps/branches) from execute and detects fetch faults. Sits between pc, instruction memory and decode in the processor core.

---
 rtl/fetch_ctrl_pkg.sv | 25 ++
 rtl/fetch_ctrl_if.sv | 32 +++
 rtl/fetch_ctrl_timer.sv | 39 +++
 rtl/fetch_ctrl.sv | 126 ++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Imported by the fetch interface, the fetch timer and the top.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    ST_START   = 3'd0,
    ST_FETCH   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_HALTED  = 3'd3,
    ST_FAULTED = 3'd4
  } state_e;

  localparam logic PC_MODE_INC  = 1'b0;
  localparam logic PC_MODE_LOAD = 1'b1;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h1A00_0000;

  // Instruction addresses must be word aligned.
  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Signal bundle between fetch_ctrl and its neighbours (pc, imem, decode, execute).
// master = the fetch controller, slave = the surrounding core / environment.
interface fetch_ctrl_if;
  import fetch_ctrl_pkg::*;

  logic [XLEN-1:0] PC_OUT;
  logic [XLEN-1:0] PC_D;
  logic            PC_MODE;
  logic            PC_ENABLE;
  logic [XLEN-1:0] IMEM_ADDR;
  logic            IMEM_REQ;
  logic            IMEM_READY;
  logic [XLEN-1:0] IMEM_RDATA;
  logic [XLEN-1:0] INSTR;
  logic            INSTR_VALID;
  logic            INSTR_ACCEPT;
  logic            JUMP_REQ;
  logic [XLEN-1:0] JUMP_TARGET;
  logic            HALT;
  logic            FAULT;

  modport master (
    input  PC_OUT, IMEM_READY, IMEM_RDATA, INSTR_ACCEPT, JUMP_REQ, JUMP_TARGET, HALT,
    output PC_D, PC_MODE, PC_ENABLE, IMEM_ADDR, IMEM_REQ, INSTR, INSTR_VALID, FAULT
  );

  modport slave (
    output PC_OUT, IMEM_READY, IMEM_RDATA, INSTR_ACCEPT, JUMP_REQ, JUMP_TARGET, HALT,
    input  PC_D, PC_MODE, PC_ENABLE, IMEM_ADDR, IMEM_REQ, INSTR, INSTR_VALID, FAULT
  );

endinterface

// File: rtl/fetch_ctrl_timer.sv
// Clearable saturating counter of unanswered fetch cycles.
// expired flags the cycle whose increment reaches FETCH_TIMEOUT; 0 disables it.
module fetch_timer #(
  parameter int unsigned FETCH_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  if (FETCH_TIMEOUT == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = ^{clk, rst, clr, inc};
    assign expired    = 1'b0;
  end else begin : g_on
    localparam int unsigned CW = $clog2(FETCH_TIMEOUT + 1);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
      count_d = count_q;
      if (clr) begin
        count_d = '0;
      end else if (inc && (count_q != CW'(FETCH_TIMEOUT))) begin
        count_d = count_q + CW'(1);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
    end

    assign expired = inc && (count_q == CW'(FETCH_TIMEOUT - 1));
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: steers pc, issues imem reads and hands instructions to decode.
// Redirects from execute override fetch/accept; faults are sticky until reset.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned FETCH_TIMEOUT = 16,
  parameter bit          ALIGN_CHECK   = 1'b1
) (
  input  logic          CLK,
  input  logic          RES,
  fetch_ctrl_if.master  bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic            instr_valid_q, instr_valid_d;
  logic            fault_q, fault_d;

  logic            pc_enable_c;
  logic            pc_mode_c;
  logic [XLEN-1:0] pc_d_c;
  logic            imem_req_c;
  logic [XLEN-1:0] imem_addr_c;

  logic            tmr_inc, tmr_clr, tmr_expired;
  logic            jump_live, jump_bad;

  assign jump_live = bus.JUMP_REQ &&
                     ((state_q == ST_FETCH) || (state_q == ST_HOLD) || (state_q == ST_HALTED));
  assign jump_bad  = ALIGN_CHECK && misaligned(bus.JUMP_TARGET[1:0]);

  // Next state, captured instruction and combinational pc/imem controls.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    pc_enable_c = 1'b0;
    pc_mode_c   = PC_MODE_INC;
    pc_d_c      = '0;
    imem_req_c  = (state_q == ST_FETCH);
    imem_addr_c = imem_req_c ? bus.PC_OUT : '0;
    tmr_inc     = 1'b0;

    if (jump_live) begin
      if (jump_bad) begin
        state_d = ST_FAULTED;
      end else begin
        pc_enable_c = 1'b1;
        pc_mode_c   = PC_MODE_LOAD;
        pc_d_c      = bus.JUMP_TARGET;
        state_d     = ((state_q == ST_HALTED) && bus.HALT) ? ST_HALTED : ST_FETCH;
      end
    end else begin
      case (state_q)
        ST_START: state_d = bus.HALT ? ST_HALTED : ST_FETCH;
        ST_FETCH: begin
          if (bus.IMEM_READY) begin
            instr_d = bus.IMEM_RDATA;
            state_d = ST_HOLD;
          end else begin
            tmr_inc = 1'b1;
            if (tmr_expired) state_d = ST_FAULTED;
          end
        end
        ST_HOLD: begin
          if (bus.INSTR_ACCEPT) begin
            pc_enable_c = 1'b1;
            pc_mode_c   = PC_MODE_INC;
            state_d     = bus.HALT ? ST_HALTED : ST_FETCH;
          end
        end
        ST_HALTED: begin
          if (!bus.HALT) state_d = ST_FETCH;
        end
        ST_FAULTED: state_d = ST_FAULTED;
        default:    state_d = ST_FAULTED;
      endcase
    end

    instr_valid_d = (state_d == ST_HOLD);
    fault_d       = (state_d == ST_FAULTED);
  end

  // Any cycle that is not an unanswered, unredirected fetch restarts the count.
  assign tmr_clr = !tmr_inc;

  fetch_timer #(
    .FETCH_TIMEOUT (FETCH_TIMEOUT)
  ) u_timer (
    .clk     (CLK),
    .rst     (RES),
    .clr     (tmr_clr),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q       <= ST_START;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.PC_ENABLE   = pc_enable_c;
  assign bus.PC_MODE     = pc_mode_c;
  assign bus.PC_D        = pc_d_c;
  assign bus.IMEM_REQ    = imem_req_c;
  assign bus.IMEM_ADDR   = imem_addr_c;
  assign bus.INSTR       = instr_q;
  assign bus.INSTR_VALID = instr_valid_q;
  assign bus.FAULT       = fault_q;

  // pc must never move while starting up or after a fault.
  a_no_enable_idle: assert property (@(posedge CLK) disable iff (RES)
    ((state_q == ST_START) || (state_q == ST_FAULTED)) |-> !pc_enable_c);

  a_no_req_unless_fetch: assert property (@(posedge CLK) disable iff (RES)
    imem_req_c |-> (state_q == ST_FETCH));

endmodule
